// File: rtl/pulse_stretcher_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pulse_stretcher_pkg
// Purpose  : Shared types and constants for the pulse_stretcher block.
// Revision : 1.0 - initial release
// ============================================================================
package pulse_stretcher_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam int c_pend_w_def   = 4;
  localparam int c_pend_sat_def = (1 << c_pend_w_def) - 1;

  // Largest count a pending counter of the given width can hold.
  function automatic int pend_sat(input int width);
    return (1 << width) - 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pulse_stretcher_sync2.sv
`default_nettype none
// ============================================================================
// Module   : sync2
// Purpose  : Two-flop single-bit synchronizer with synchronous reset to 0.
// Revision : 1.0 - initial release
// ============================================================================
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule
`default_nettype wire

// File: rtl/pulse_stretcher.sv
`default_nettype none
// ============================================================================
// Module   : pulse_stretcher
// Purpose  : Turns input rising edges into fixed HOLD-high / GAP-low blinks,
//            queueing events that arrive mid-blink. Optional input
//            synchronizer enabled by PULSE_STRETCHER_SYNC_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pulse_stretcher
  import pulse_stretcher_pkg::*;
#(
  parameter int HOLD   = 2500000,
  parameter int GAP    = 2500000,
  parameter int CNT_W  = 22,
  parameter int PEND_W = c_pend_w_def
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in,
  output logic              out,
  output logic              busy,
  output logic [PEND_W-1:0] pending,
  output logic              dropped
);

  localparam logic [CNT_W-1:0]  c_hold_ld  = CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0]  c_gap_ld   = CNT_W'(GAP - 1);
  localparam logic [PEND_W-1:0] c_pend_sat = PEND_W'(pend_sat(PEND_W));

  if (HOLD < 1 || 64'(HOLD) > (64'd1 << CNT_W)) begin : g_chk_hold
    $error("pulse_stretcher: HOLD out of range for CNT_W");
  end
  if (GAP < 1 || 64'(GAP) > (64'd1 << CNT_W)) begin : g_chk_gap
    $error("pulse_stretcher: GAP out of range for CNT_W");
  end

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [PEND_W-1:0] r_pend;
  logic [PEND_W-1:0] w_pend_nxt;
  logic              r_out;
  logic              w_out_nxt;
  logic              r_dropped;
  logic              w_dropped_nxt;
  logic              r_in_q;
  logic              w_in_s;
  logic              w_ev;
  logic              w_consume;
  logic              w_cnt_zero;

`ifdef PULSE_STRETCHER_SYNC_EN
  sync2 u_sync2 (
    .clk (clk),
    .rst (rst),
    .i_d (in),
    .o_q (w_in_s)
  );
`else
  assign w_in_s = in;
`endif

  // Resetting to 1 suppresses a false event from a level held across reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_q <= 1'b1;
    end else begin
      r_in_q <= w_in_s;
    end
  end

  assign w_ev       = w_in_s & ~r_in_q;
  assign w_cnt_zero = (r_cnt == '0);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_out_nxt   = r_out;
    w_consume   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_out_nxt = 1'b0;
        if (w_ev) begin
          w_state_nxt = S_HOLD;
          w_cnt_nxt   = c_hold_ld;
          w_out_nxt   = 1'b1;
        end
      end
      S_HOLD: begin
        w_out_nxt = 1'b1;
        if (w_cnt_zero) begin
          w_state_nxt = S_GAP;
          w_cnt_nxt   = c_gap_ld;
          w_out_nxt   = 1'b0;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_GAP: begin
        w_out_nxt = 1'b0;
        if (w_cnt_zero) begin
          // A fresh event on the final gap cycle chains straight into a blink.
          if (r_pend != '0 || w_ev) begin
            w_state_nxt = S_HOLD;
            w_cnt_nxt   = c_hold_ld;
            w_out_nxt   = 1'b1;
            w_consume   = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_out_nxt   = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_pend_nxt    = r_pend;
    w_dropped_nxt = r_dropped;
    if (r_state != S_IDLE) begin
      if (w_ev && !w_consume) begin
        if (r_pend == c_pend_sat) begin
          w_dropped_nxt = 1'b1;
        end else begin
          w_pend_nxt = r_pend + PEND_W'(1);
        end
      end else if (w_consume && !w_ev) begin
        w_pend_nxt = r_pend - PEND_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_pend    <= '0;
      r_out     <= 1'b0;
      r_dropped <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_pend    <= w_pend_nxt;
      r_out     <= w_out_nxt;
      r_dropped <= w_dropped_nxt;
    end
  end

  assign out     = r_out;
  assign busy    = (r_state != S_IDLE);
  assign pending = r_pend;
  assign dropped = r_dropped;

endmodule
`default_nettype wire

// File: tb/tb_pulse_stretcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_pulse_stretcher
// Purpose  : Self-checking bench for pulse_stretcher against a time-based
//            reference model (blink start times and an event queue count).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pulse_stretcher;

  localparam int HOLD   = 4;
  localparam int GAP    = 3;
  localparam int CNT_W  = 8;
  localparam int PEND_W = 2;
  localparam int PMAX   = (1 << PEND_W) - 1;
`ifdef PULSE_STRETCHER_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in  = 1'b0;
  logic              out;
  logic              busy;
  logic [PEND_W-1:0] pending;
  logic              dropped;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  pulse_stretcher #(
    .HOLD   (HOLD),
    .GAP    (GAP),
    .CNT_W  (CNT_W),
    .PEND_W (PEND_W)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .in      (in),
    .out     (out),
    .busy    (busy),
    .pending (pending),
    .dropped (dropped)
  );

  always #5 clk = ~clk;

  // Reference: a blink starting at edge s is high after s..s+HOLD-1 and the
  // next blink may begin exactly at s+HOLD+GAP.
  bit m_act, m_drop, m_prev, m_s1, m_s2, m_w, m_e;
  int m_start, m_pend;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_act = 0; m_pend = 0; m_drop = 0; m_prev = 1; m_s1 = 0; m_s2 = 0;
    end else begin
      m_w    = (LAT == 3) ? m_s2 : in;
      m_e    = m_w & ~m_prev;
      m_prev = m_w;
      m_s2   = m_s1;
      m_s1   = in;
      if (!m_act) begin
        if (m_e) begin m_act = 1; m_start = cyc; end
      end else if (cyc == m_start + HOLD + GAP) begin
        if (m_pend > 0 || m_e) begin
          if (m_pend > 0 && !m_e) m_pend--;
          m_start = cyc;
        end else begin
          m_act = 0;
        end
      end else if (m_e) begin
        if (m_pend < PMAX) m_pend++;
        else m_drop = 1;
      end
    end
  end

  function automatic logic [PEND_W+2:0] model_vec();
    logic mo;
    mo = m_act && ((cyc - m_start) < HOLD);
    return {mo, m_act, PEND_W'(m_pend), m_drop};
  endfunction

  task automatic drive(input logic v);
    in = v;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0);
      total++;
      if ({out, busy, pending, dropped} !== 5'b0) begin
        bad++;
        $display("FAIL reset i=%0d got=%b exp=%b", i, {out, busy, pending, dropped}, 5'b0);
      end
    end
    rst = 1'b0;
    drive(1'b0);
  endtask

  task automatic test_single();
    int highs = 0;
    int rise  = -1;
    for (int i = 0; i < 16; i++) begin
      drive(i == 0);
      total++;
      if ({out, busy, pending, dropped} !== model_vec()) begin
        bad++;
        $display("FAIL single i=%0d got=%b exp=%b", i, {out, busy, pending, dropped}, model_vec());
      end
      if (out) highs++;
      if (out && rise < 0) rise = i;
    end
    total++;
    if (highs !== HOLD) begin
      bad++; $display("FAIL single_len got=%0d exp=%0d", highs, HOLD);
    end
    total++;
    if (rise !== LAT - 1) begin
      bad++; $display("FAIL single_latency got=%0d exp=%0d", rise, LAT - 1);
    end
  endtask

  task automatic test_held();
    int blinks = 0;
    logic po = 1'b0;
    for (int i = 0; i < 32; i++) begin
      drive(i < 20);
      total++;
      if ({out, busy, pending, dropped} !== model_vec()) begin
        bad++;
        $display("FAIL held i=%0d got=%b exp=%b", i, {out, busy, pending, dropped}, model_vec());
      end
      if (out && !po) blinks++;
      po = out;
    end
    total++;
    if (blinks !== 1) begin
      bad++; $display("FAIL held_blinks got=%0d exp=1", blinks);
    end
  endtask

  task automatic test_burst();
    int blinks = 0;
    int peak   = 0;
    logic po = 1'b0;
    for (int i = 0; i < 32; i++) begin
      drive(i == 0 || i == 2 || i == 4);
      total++;
      if ({out, busy, pending, dropped} !== model_vec()) begin
        bad++;
        $display("FAIL burst i=%0d got=%b exp=%b", i, {out, busy, pending, dropped}, model_vec());
      end
      if (out && !po) blinks++;
      po = out;
      if (int'(pending) > peak) peak = int'(pending);
    end
    total++;
    if (blinks !== 3 || peak !== 2) begin
      bad++; $display("FAIL burst_shape blinks=%0d peak=%0d exp 3/2", blinks, peak);
    end
  endtask

  task automatic test_back_to_back();
    int blinks = 0;
    logic po = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(i == 0 || i == HOLD + GAP);
      total++;
      if ({out, busy, pending, dropped} !== model_vec()) begin
        bad++;
        $display("FAIL b2b i=%0d got=%b exp=%b", i, {out, busy, pending, dropped}, model_vec());
      end
      if (i >= LAT - 1 && i < LAT - 1 + 2 * (HOLD + GAP)) begin
        total++;
        if (busy !== 1'b1 || pending !== '0) begin
          bad++; $display("FAIL b2b_busy i=%0d busy=%b pending=%0d exp 1/0", i, busy, pending);
        end
      end
      if (out && !po) blinks++;
      po = out;
    end
    total++;
    if (blinks !== 2) begin
      bad++; $display("FAIL b2b_blinks got=%0d exp=2", blinks);
    end
  endtask

  task automatic test_saturation();
    int blinks = 0;
    int peak   = 0;
    logic po = 1'b0;
    for (int i = 0; i < 48; i++) begin
      drive(i < 12 && (i % 2 == 0));
      total++;
      if ({out, busy, pending, dropped} !== model_vec()) begin
        bad++;
        $display("FAIL sat i=%0d got=%b exp=%b", i, {out, busy, pending, dropped}, model_vec());
      end
      if (out && !po) blinks++;
      po = out;
      if (int'(pending) > peak) peak = int'(pending);
    end
    total++;
    if (blinks !== 5 || peak !== PMAX || dropped !== 1'b1) begin
      bad++;
      $display("FAIL sat_shape blinks=%0d peak=%0d dropped=%b exp 5/%0d/1", blinks, peak, dropped, PMAX);
    end
  endtask

  task automatic test_reset_mid();
    bit found = 0;
    for (int i = 0; i < 8; i++) drive(i % 2 == 0);
    for (int i = 0; i < 20 && !found; i++) begin
      if (model_vec() == {2'b11, PEND_W'(2), 1'b1}) found = 1;
      else drive(1'b0);
    end
    total++;
    if (!found || pending !== PEND_W'(2) || out !== 1'b1) begin
      bad++; $display("FAIL rstmid_setup out=%b pending=%0d exp 1/2", out, pending);
    end
    rst = 1'b1;
    drive(1'b0);
    rst = 1'b0;
    total++;
    if ({out, busy, pending, dropped} !== 5'b0) begin
      bad++; $display("FAIL rstmid got=%b exp=%b", {out, busy, pending, dropped}, 5'b0);
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0);
      total++;
      if ({out, busy, pending, dropped} !== model_vec()) begin
        bad++;
        $display("FAIL rstmid_after i=%0d got=%b exp=%b", i, {out, busy, pending, dropped}, model_vec());
      end
    end
  endtask

  task automatic test_held_reset();
    int highs = 0;
    rst = 1'b1;
    drive(1'b1);
    drive(1'b1);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      drive(i < 12);
      total++;
      if ({out, busy, pending, dropped} !== model_vec()) begin
        bad++;
        $display("FAIL heldrst i=%0d got=%b exp=%b", i, {out, busy, pending, dropped}, model_vec());
      end
      if (out) highs++;
    end
`ifndef PULSE_STRETCHER_SYNC_EN
    total++;
    if (highs !== 0) begin
      bad++; $display("FAIL heldrst_noblink got=%0d exp=0", highs);
    end
`endif
  endtask

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      rst = ($urandom_range(0, 149) == 0);
      drive($urandom_range(0, 2) == 0);
      total++;
      if ({out, busy, pending, dropped} !== model_vec()) begin
        bad++;
        $display("FAIL random i=%0d got=%b exp=%b", i, {out, busy, pending, dropped}, model_vec());
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_held();
    test_burst();
    test_back_to_back();
    test_saturation();
    test_reset_mid();
    test_held_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
